rsa_avm_wrapper: RTL and testbench

// - Host-side controller for the RSA decryption core: Avalon-MM master that polls the RS232 UART.
// - Loads the key (n, then d) and one ciphertext block, then pulses the core start.
// - Streams the plaintext back through the UART, then waits for the next block with the key kept.
// - Sits between the UART Avalon slave and the RSA core; the core is a sibling instance in the top level.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_avm_wrapper.sv | 180 ++++++++++++++++++
 tb/tb_rsa_avm_wrapper.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA host-side Avalon-MM controller.
// UART register map, status bit positions and the controller state type.
package rsa_pkg;

  localparam logic [4:0] RX_BASE     = 5'h00;
  localparam logic [4:0] TX_BASE     = 5'h04;
  localparam logic [4:0] STATUS_BASE = 5'h08;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;

  typedef enum logic [2:0] {
    S_QUERY_RX,
    S_READ,
    S_START,
    S_WAIT,
    S_QUERY_TX,
    S_WRITE
  } state_t;

endpackage

// File: rtl/rsa_avm_wrapper.sv
// Avalon-MM master that polls the RS232 UART, loads the key (n, d) and one
// ciphertext block a, starts the RSA core and streams the plaintext back.
// Ports: i_clk/i_rst (sync, active-high); o_avm_* / i_avm_* Avalon master to
// the UART slave; o_core_start/a/d/n and i_core_result/finished to the core.
module rsa_avm_wrapper
  import rsa_pkg::*;
#(
  parameter int BITWIDTH = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  output logic [4:0]          o_avm_address,
  output logic                o_avm_read,
  input  logic [31:0]         i_avm_readdata,
  output logic                o_avm_write,
  output logic [31:0]         o_avm_writedata,
  input  logic                i_avm_waitreq,
  output logic                o_core_start,
  output logic [BITWIDTH-1:0] o_core_a,
  output logic [BITWIDTH-1:0] o_core_d,
  output logic [BITWIDTH-1:0] o_core_n,
  input  logic [BITWIDTH-1:0] i_core_result,
  input  logic                i_core_finished
);

  localparam int NBYTES = BITWIDTH / 8;
  localparam int CW     = $clog2(2 * NBYTES);

  localparam logic [CW-1:0] LAST_KEY = CW'(2 * NBYTES - 1);
  localparam logic [CW-1:0] LAST_A   = CW'(NBYTES - 1);
  localparam logic [CW-1:0] LAST_TX  = CW'(NBYTES - 2);
  localparam logic [CW-1:0] N_BYTES  = CW'(NBYTES);

  state_t              state_r, state_w;
  logic [CW-1:0]       cnt_r, cnt_w;
  logic                key_r, key_w;
  logic [BITWIDTH-1:0] n_r, n_w;
  logic [BITWIDTH-1:0] d_r, d_w;
  logic [BITWIDTH-1:0] a_r, a_w;
  logic [BITWIDTH-1:0] send_r, send_w;
  logic                read_r, read_w;
  logic                write_r, write_w;
  logic [4:0]          addr_r, addr_w;
  logic [7:0]          wdata_r, wdata_w;

  logic [7:0] byte_in;
  logic       done;
  logic       unused_rdata;

  assign byte_in      = i_avm_readdata[7:0];
  assign done         = (read_r | write_r) & ~i_avm_waitreq;
  assign unused_rdata = ^i_avm_readdata[31:8];

  always_comb begin
    state_w = state_r;
    cnt_w   = cnt_r;
    key_w   = key_r;
    n_w     = n_r;
    d_w     = d_r;
    a_w     = a_r;
    send_w  = send_r;
    read_w  = read_r;
    write_w = write_r;
    addr_w  = addr_r;
    wdata_w = wdata_r;
    case (state_r)
      S_QUERY_RX: begin
        if (!read_r) begin
          read_w = 1'b1;
          addr_w = STATUS_BASE;
        end else if (done) begin
          read_w = 1'b0;
          if (i_avm_readdata[RX_OK_BIT]) state_w = S_READ;
        end
      end
      S_READ: begin
        if (!read_r) begin
          read_w = 1'b1;
          addr_w = RX_BASE;
        end else if (done) begin
          read_w  = 1'b0;
          state_w = S_QUERY_RX;
          if (!key_r) begin
            if (cnt_r < N_BYTES)
              n_w = {n_r[BITWIDTH-9:0], byte_in};
            else
              d_w = {d_r[BITWIDTH-9:0], byte_in};
            if (cnt_r == LAST_KEY) begin
              key_w = 1'b1;
              cnt_w = '0;
            end else begin
              cnt_w = cnt_r + 1'b1;
            end
          end else begin
            a_w = {a_r[BITWIDTH-9:0], byte_in};
            if (cnt_r == LAST_A) begin
              cnt_w   = '0;
              state_w = S_START;
            end else begin
              cnt_w = cnt_r + 1'b1;
            end
          end
        end
      end
      S_START: state_w = S_WAIT;
      S_WAIT: begin
        if (i_core_finished) begin
          send_w  = i_core_result;
          state_w = S_QUERY_TX;
        end
      end
      S_QUERY_TX: begin
        if (!read_r) begin
          read_w = 1'b1;
          addr_w = STATUS_BASE;
        end else if (done) begin
          read_w = 1'b0;
          if (i_avm_readdata[TX_OK_BIT]) state_w = S_WRITE;
        end
      end
      S_WRITE: begin
        // Top byte is never sent: plaintext < n.
        if (!write_r) begin
          write_w = 1'b1;
          addr_w  = TX_BASE;
          wdata_w = send_r[BITWIDTH-9 -: 8];
        end else if (done) begin
          write_w = 1'b0;
          send_w  = send_r << 8;
          if (cnt_r == LAST_TX) begin
            cnt_w   = '0;
            state_w = S_QUERY_RX;
          end else begin
            cnt_w   = cnt_r + 1'b1;
            state_w = S_QUERY_TX;
          end
        end
      end
      default: state_w = S_QUERY_RX;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_QUERY_RX;
      cnt_r   <= '0;
      key_r   <= 1'b0;
      n_r     <= '0;
      d_r     <= '0;
      a_r     <= '0;
      send_r  <= '0;
      read_r  <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_w;
      cnt_r   <= cnt_w;
      key_r   <= key_w;
      n_r     <= n_w;
      d_r     <= d_w;
      a_r     <= a_w;
      send_r  <= send_w;
      read_r  <= read_w;
      write_r <= write_w;
      addr_r  <= addr_w;
      wdata_r <= wdata_w;
    end
  end

  assign o_avm_address   = addr_r;
  assign o_avm_read      = read_r;
  assign o_avm_write     = write_r;
  assign o_avm_writedata = {24'd0, wdata_r};
  assign o_core_start    = (state_r == S_START);
  assign o_core_a        = a_r;
  assign o_core_d        = d_r;
  assign o_core_n        = n_r;

endmodule

// File: tb/tb_rsa_avm_wrapper.sv
// Directed bench for rsa_avm_wrapper: behavioural UART slave with random
// waitrequest, stub RSA core (a^d mod n after 10 cycles), immediate asserts.
module tb_rsa_avm_wrapper;

  localparam int BW = 256;
  localparam int NB = BW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    address;
  logic          read;
  logic [31:0]   rdata = '0;
  logic          write;
  logic [31:0]   wdata;
  logic          waitreq = 1'b0;
  logic          start;
  logic [BW-1:0] core_a, core_d, core_n;
  logic [BW-1:0] core_result;
  logic          core_fin;

  always #5 clk = ~clk;

  rsa_avm_wrapper #(.BITWIDTH(BW)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .o_avm_address   (address),
    .o_avm_read      (read),
    .i_avm_readdata  (rdata),
    .o_avm_write     (write),
    .o_avm_writedata (wdata),
    .i_avm_waitreq   (waitreq),
    .o_core_start    (start),
    .o_core_a        (core_a),
    .o_core_d        (core_d),
    .o_core_n        (core_n),
    .i_core_result   (core_result),
    .i_core_finished (core_fin)
  );

  // stimulus-side controls (written only by the initial block)
  logic [7:0] rx_mem [0:511];
  int         rx_wr = 0;
  logic       tx_en = 1'b1;
  logic       rx_stall_mode = 1'b0;
  logic       man_fin = 1'b0;

  // slave/monitor-side state (written only by the always blocks)
  int         rx_rd = 0;
  logic [7:0] tx_mem [0:511];
  int         tx_cnt = 0;
  int         write_count = 0;
  int         status_reads = 0;
  int         starts = 0;
  int         proto_bad = 0;
  logic       busy = 1'b0;
  int         stall = 0;
  logic       hold_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic       start_prev = 1'b0;
  logic [38:0] hold_sig = '0;

  logic          stub_fin = 1'b0;
  logic [BW-1:0] stub_res = '0;
  logic [BW-1:0] sa, sd, sn;
  int            stub_cnt = 0;

  int errors = 0;
  int checks = 0;

  assign core_fin    = stub_fin | man_fin;
  assign core_result = man_fin ? 256'hAB : stub_res;

  function automatic logic [BW-1:0] modexp(logic [BW-1:0] b, logic [BW-1:0] e,
                                           logic [BW-1:0] m);
    logic [2*BW-1:0] r, x, mm;
    if (m == 0) return '0;
    mm = {{BW{1'b0}}, m};
    r  = 1;
    x  = {{BW{1'b0}}, b} % mm;
    for (int i = 0; i < BW; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    r = r % mm;
    return r[BW-1:0];
  endfunction

  // UART slave: waitreq/readdata driven on the falling edge
  always @(negedge clk) begin
    if (rst || !(read || write)) begin
      busy    = 1'b0;
      waitreq = 1'b0;
    end else begin
      if (!busy) begin
        busy = 1'b1;
        if (rx_stall_mode && read && address == 5'h00) stall = 5;
        else stall = $urandom_range(0, 3);
      end
      if (stall > 0) begin
        waitreq = 1'b1;
        stall--;
      end else begin
        waitreq = 1'b0;
      end
    end
    case (address)
      5'h08:   rdata = {24'd0, rx_rd < rx_wr, tx_en, 6'd0};
      5'h00:   rdata = {24'd0, rx_mem[rx_rd]};
      default: rdata = '0;
    endcase
  end

  // transaction bookkeeping and protocol monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (hold_prev && ({read, write, address, wdata} !== hold_sig)) proto_bad++;
      if (done_prev && (read || write)) proto_bad++;
      if (read && write) proto_bad++;
      if (start && start_prev) proto_bad++;
      if (start) starts++;
      if ((read || write) && !waitreq) begin
        if (write && address == 5'h04) begin
          tx_mem[tx_cnt] = wdata[7:0];
          tx_cnt++;
          write_count++;
        end
        if (read && address == 5'h00) rx_rd++;
        if (read && address == 5'h08) status_reads++;
      end
    end
    hold_prev  = !rst && (read || write) && waitreq;
    done_prev  = !rst && (read || write) && !waitreq;
    start_prev = !rst && start;
    hold_sig   = {read, write, address, wdata};
  end

  // stub RSA core
  always @(negedge clk) begin
    if (rst) begin
      stub_cnt = 0;
      stub_fin = 1'b0;
    end else begin
      stub_fin = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          stub_fin = 1'b1;
          stub_res = modexp(sa, sd, sn);
        end
      end
      if (start) begin
        stub_cnt = 10;
        sa = core_a;
        sd = core_d;
        sn = core_n;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_val(logic [BW-1:0] v);
    for (int i = NB - 1; i >= 0; i--) begin
      rx_mem[rx_wr] = v[i*8 +: 8];
      rx_wr++;
    end
  endtask

  task automatic push_byte(logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic wait_tx(int base, int budget);
    for (int i = 0; i < budget && tx_cnt - base < NB - 1; i++) tick();
  endtask

  task automatic check_block(string tag, int base, logic [7:0] last);
    logic [7:0] acc;
    acc = '0;
    chk({tag, "_count"}, BW'(tx_cnt - base), BW'(NB - 1));
    for (int i = 0; i < NB - 2 && base + i < tx_cnt; i++) acc |= tx_mem[base + i];
    chk({tag, "_zeros"}, BW'(acc), '0);
    chk({tag, "_last"}, BW'(tx_mem[base + NB - 2]), BW'(last));
  endtask

  int base;
  int wbase;
  int sbase;

  initial begin
    // 1: reset held with RX data available
    push_val(256'd33);
    push_val(256'd3);
    push_val(256'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_idle", BW'({read, write, start}), '0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20 && !(read || write); i++) tick();
    chk("first_access", BW'({read, write, address}), BW'({1'b1, 1'b0, 5'h08}));

    // 2: key n=33 d=3 and a=4 -> 64 mod 33 = 0x1F
    base = tx_cnt;
    wait_tx(base, 6000);
    chk("t2_starts", BW'(starts), BW'(1));
    chk("t2_n", core_n, 256'd33);
    chk("t2_d", core_d, 256'd3);
    chk("t2_a", core_a, 256'd4);
    check_block("t2", base, 8'h1F);

    // 3: second block a=5, key kept -> 125 mod 33 = 0x1A
    base = tx_cnt;
    push_val(256'd5);
    wait_tx(base, 4000);
    chk("t3_starts", BW'(starts), BW'(2));
    chk("t3_n", core_n, 256'd33);
    chk("t3_d", core_d, 256'd3);
    chk("t3_a", core_a, 256'd5);
    check_block("t3", base, 8'h1A);

    // 4: RX read stalled for 5 cycles
    rx_stall_mode = 1'b1;
    push_byte(8'h00);
    for (int i = 0; i < 100 && !(read && address == 5'h00); i++) tick();
    chk("t4_rx_read", BW'({read, address}), BW'({1'b1, 5'h00}));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stable", BW'({read, write, address}), BW'({1'b1, 1'b0, 5'h00}));
    end
    for (int i = 0; i < 20 && rx_rd < rx_wr; i++) tick();
    rx_stall_mode = 1'b0;
    repeat (4) tick();
    chk("t4_one_byte", core_a, 256'h500);
    chk("t4_consumed", BW'(rx_rd), BW'(rx_wr));

    // 5: TX_OK held low, then a=2 -> 8
    tx_en = 1'b0;
    for (int i = 0; i < NB - 2; i++) push_byte(8'h00);
    push_byte(8'h02);
    for (int i = 0; i < 3000 && starts < 3; i++) tick();
    chk("t5_starts", BW'(starts), BW'(3));
    chk("t5_a", core_a, 256'd2);
    repeat (20) tick();
    sbase = status_reads;
    wbase = write_count;
    for (int i = 0; i < 3000 && status_reads - sbase < 100; i++) tick();
    chk("t5_polls", BW'(status_reads - sbase >= 100), BW'(1));
    chk("t5_no_write", BW'({write_count - wbase, write}), '0);
    base = tx_cnt;
    tx_en = 1'b1;
    wait_tx(base, 3000);
    check_block("t5", base, 8'h08);

    // finished pulse while idle in S_QUERY_RX is ignored
    repeat (10) tick();
    wbase = write_count;
    man_fin = 1'b1;
    tick();
    man_fin = 1'b0;
    repeat (200) tick();
    chk("t5_fin_ignored", BW'({write_count - wbase, starts}), BW'({32'd0, 32'd3}));

    // 6: reset mid-ciphertext after 10 bytes of a
    for (int i = 0; i < 10; i++) push_byte(8'h00);
    for (int i = 0; i < 500 && rx_rd < rx_wr; i++) tick();
    chk("t6_consumed", BW'(rx_rd), BW'(rx_wr));
    rst = 1'b1;
    tick();
    chk("t6_rst_avm", BW'({read, write, address, wdata, start}), '0);
    chk("t6_rst_core", BW'({core_a, core_d, core_n} != 0), '0);
    tick();
    rst = 1'b0;
    base = tx_cnt;
    push_val(256'd59);
    push_val(256'd5);
    push_val(256'd3);
    wait_tx(base, 8000);
    chk("t6_starts", BW'(starts), BW'(4));
    chk("t6_n", core_n, 256'd59);
    chk("t6_d", core_d, 256'd5);
    chk("t6_a", core_a, 256'd3);
    check_block("t6", base, 8'h07);

    chk("protocol", BW'(proto_bad), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
